// File: rtl/cla_pkg.sv
// ============================================================================
// Module : cla_pkg
// Brief  : Shared constants, helpers and width check for the CLA adder family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef CLA_PKG_MACROS
`define CLA_PKG_MACROS
`define CLA_WIDTH_OK(W) (((W) >= 4) && ((W) <= 64) && (((W) % 4) == 0))
`endif

package cla_pkg;

    localparam int CLA_GRP = 4;

    function automatic int cla_num_groups(input int width);
        return width / CLA_GRP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_group_pg.sv
// ============================================================================
// Module : cla_group_pg
// Brief  : 4-bit lookahead group: block propagate/generate plus in-group carries.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_group_pg (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic       bp,
    output logic       bg,
    output logic [3:0] c
);

    assign bp = &p;
    assign bg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    // c[i] is the carry into bit i of the group
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
// ============================================================================
// Module : pipelined_cla_adder
// Brief  : Two-stage elastic carry-lookahead adder/subtractor with overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NG = cla_num_groups(WIDTH);

    generate
        if (!`CLA_WIDTH_OK(WIDTH)) begin : g_bad_width
            $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
        end
    endgenerate

    logic             r_v1;
    logic             r_v2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_eff;
    logic             r_c0;
    logic [NG-1:0]    r_bp;
    logic [NG-1:0]    r_bg;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic [WIDTH-1:0] w_p1;
    logic [WIDTH-1:0] w_g1;
    logic [NG-1:0]    w_bp1;
    logic [NG-1:0]    w_bg1;
    logic [WIDTH-1:0] w_unused_c1;
    logic [WIDTH-1:0] w_p2;
    logic [WIDTH-1:0] w_g2;
    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_c2;
    logic [NG-1:0]    w_unused_bp2;
    logic [NG-1:0]    w_unused_bg2;

    assign w_s2_load = !r_v2 || out_ready;
    assign w_s1_load = !r_v1 || w_s2_load;
    assign in_ready  = w_s1_load;

    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub | c_in;
    assign w_p1    = a ^ w_b_eff;
    assign w_g1    = a & w_b_eff;

    // S1 needs only BP/BG; the in-group carries are recomputed in S2
    generate
        for (genvar k = 0; k < NG; k++) begin : g_s1_grp
            cla_group_pg u_pg (
                .p   (w_p1[4*k +: 4]),
                .g   (w_g1[4*k +: 4]),
                .cin (1'b0),
                .bp  (w_bp1[k]),
                .bg  (w_bg1[k]),
                .c   (w_unused_c1[4*k +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_a     <= '0;
            r_b_eff <= '0;
            r_c0    <= 1'b0;
            r_bp    <= '0;
            r_bg    <= '0;
        end else begin
            if (w_s1_load) begin
                r_v1 <= in_valid;
            end
            if (in_valid && w_s1_load) begin
                r_a     <= a;
                r_b_eff <= w_b_eff;
                r_c0    <= w_c0;
                r_bp    <= w_bp1;
                r_bg    <= w_bg1;
            end
        end
    end

    assign w_p2 = r_a ^ r_b_eff;
    assign w_g2 = r_a & r_b_eff;

    always_comb begin
        w_gc[0] = r_c0;
        for (int k = 0; k < NG; k++) begin
            w_gc[k+1] = r_bg[k] | (r_bp[k] & w_gc[k]);
        end
    end

    generate
        for (genvar k = 0; k < NG; k++) begin : g_s2_grp
            cla_group_pg u_pg (
                .p   (w_p2[4*k +: 4]),
                .g   (w_g2[4*k +: 4]),
                .cin (w_gc[k]),
                .bp  (w_unused_bp2[k]),
                .bg  (w_unused_bg2[k]),
                .c   (w_c2[4*k +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_v2 <= r_v1;
            end
            if (r_v1 && w_s2_load) begin
                r_sum  <= w_p2 ^ w_c2;
                r_cout <= w_gc[NG];
                r_ovf  <= w_c2[WIDTH-1] ^ w_gc[NG];
            end
        end
    end

    assign out_valid = r_v2;
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
// ============================================================================
// Module : tb_pipelined_cla_adder
// Brief  : Self-checking bench: reference model with in-order result queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        c_in, sub, c_out, ovf;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, sum32;
    logic        c_in32, sub32, c_out32, ovf32;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        c_in4, sub4, c_out4, ovf4;

    int          total = 0;
    int          bad   = 0;
    logic [17:0] q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    pipelined_cla_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .c_in(c_in32), .sub(sub32), .out_valid(out_valid32),
        .out_ready(out_ready32), .sum(sum32), .c_out(c_out32), .ovf(ovf32)
    );

    pipelined_cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .c_in(c_in4), .sub(sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .sum(sum4), .c_out(c_out4), .ovf(ovf4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Returns {ovf, c_out, sum} from plain integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [16:0] u;
        int          sr;
        if (ms) begin
            u  = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
            sr = int'($signed(ma)) - int'($signed(mb));
        end else begin
            u  = {1'b0, ma} + {1'b0, mb} + {16'b0, mc};
            sr = int'($signed(ma)) + int'($signed(mb)) + (mc ? 1 : 0);
        end
        return {(sr > 32767) || (sr < -32768), u[16], u[15:0]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream: got result %0h required no result", sum);
                end else begin
                    chk("stream", 64'({ovf, c_out, sum}), 64'(q[0]));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, c_in, sub));
        end
    end

    // Caller is at posedge+2; returns at posedge+2 after the accepting edge
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic ts);
        int   n;
        logic acc;
        n = 0;
        a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready 0 required 1 within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic tc, input logic ts, input logic [17:0] exp);
        send(ta, tb_v, tc, ts);
        @(negedge clk);
        chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk(nm, 64'({ovf, c_out, sum}), 64'(exp));
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int cyc;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; c_in32 = 1'b0; sub32 = 1'b0;
        in_valid4  = 1'b0; out_ready4  = 1'b1; a4  = '0; b4  = '0; c_in4  = 1'b0; sub4  = 1'b0;

        // Reset state, with in_valid held high to show nothing is taken
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_c_out",     64'(c_out),     64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #2;
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_accept", 64'(out_valid), 64'd0);
        @(posedge clk);
        #2;

        chk("model_add_wrap", 64'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 64'({1'b0, 1'b1, 16'h0000}));
        chk("model_add_ovf",  64'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 64'({1'b1, 1'b0, 16'h8000}));
        chk("model_sub_neg",  64'(model(16'h0005, 16'h0007, 1'b1, 1'b1)), 64'({1'b0, 1'b0, 16'hFFFE}));
        chk("model_sub_ovf",  64'(model(16'h8000, 16'h0001, 1'b1, 1'b1)), 64'({1'b1, 1'b1, 16'h7FFF}));

        directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        directed("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        directed("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});

        // Full-chain propagate on the 32-bit and single-group instances
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; c_in32 = 1'b1; in_valid32 = 1'b1;
        a4  = 4'hF; b4 = 4'h1; c_in4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        chk("w32_in_ready", 64'(in_ready32), 64'd1);
        chk("w4_in_ready",  64'(in_ready4),  64'd1);
        @(posedge clk);
        #2;
        in_valid32 = 1'b0; in_valid4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("w32_valid",  64'(out_valid32), 64'd1);
        chk("w32_result", 64'({ovf32, c_out32, sum32}), 64'({1'b0, 1'b1, 32'h0}));
        chk("w4_valid",   64'(out_valid4), 64'd1);
        chk("w4_result",  64'({ovf4, c_out4, sum4}), 64'({1'b0, 1'b1, 4'h0}));
        @(posedge clk);
        #2;

        // Back-pressure: 4 streamed ops, out_ready low for 5 cycles
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(16'(i), 16'h0100, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                    chk("bp_stall_sum", 64'({out_valid, sum}), 64'({1'b1, 16'h0100}));
                end
                @(posedge clk);
                #2;
                out_ready = 1'b1;
                #1;
                chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    chk("bp_drain", 64'({out_valid, sum}), 64'({1'b1, 16'h0100 + 16'(j)}));
                end
                @(posedge clk);
                #2;
            end
        join
        repeat (3) @(posedge clk);
        #2;

        // Reset while both stages hold data
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, 1'b0, 1'b0);
        send(16'h0003, 16'h0004, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_before_rst", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'({out_valid, in_ready, sum}), 64'({1'b0, 1'b1, 16'h0}));
        @(posedge clk);
        #2;
        rst = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_discard", 64'(out_valid), 64'd0);
        @(posedge clk);
        #2;

        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < 10000 && cyc < 60000) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? ~a : 16'($urandom);
            c_in = 1'($urandom);
            sub = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
            @(posedge clk);
            #2;
            cyc++;
        end
        chk("random_accepts", 64'(acc_cnt), 64'd10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
